aes_ctr_datapath: RTL

Counter datapath that sits directly upstream of the AES CTR-mode slice-increment FSM. Holds the 128-bit counter as 8 × 16-bit slices and accepts software IV writes. Serves slices to the FSM by index and writes back incremented slices. Converts a level request from cipher control into one FSM increment, and returns a one-cycle acknowledge when all slices are written; protocol violations are reported as a sticky error that drives the FSM's increment-error input.

---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_ctr_slice_regs.sv | 33 +++
 rtl/prim_sparse_fsm_flop.sv | 17 +
 rtl/aes_ctr_datapath.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants for the AES CTR counter datapath: slice geometry and the
// sparse state encoding of the increment controller.
package aes_pkg;

  localparam int SliceSizeCtr  = 16;
  localparam int NumSlicesCtr  = 8;
  localparam int SliceIdxWidth = $clog2(NumSlicesCtr);

  // 5-bit sparse encoding, pairwise Hamming distance >= 3, so a single upset
  // never lands on another legal state.
  localparam int         CtrStateWidth = 5;
  localparam logic [4:0] CTR_IDLE  = 5'b10010;
  localparam logic [4:0] CTR_BUSY  = 5'b01011;
  localparam logic [4:0] CTR_DONE  = 5'b11101;
  localparam logic [4:0] CTR_ERROR = 5'b00100;

endpackage

// File: rtl/aes_ctr_slice_regs.sv
// Counter slice register array: per-slice software and hardware write enables
// plus the slice read mux feeding the increment FSM.
module aes_ctr_slice_regs #(
  parameter int NumSlices = 8,
  parameter int SliceSize = 16,
  parameter int IdxWidth  = $clog2(NumSlices)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumSlices-1:0]                sw_we_i,
  input  logic [NumSlices-1:0][SliceSize-1:0] sw_data_i,
  input  logic [NumSlices-1:0]                hw_we_i,
  input  logic [SliceSize-1:0]                hw_data_i,
  input  logic [IdxWidth-1:0]                 rd_idx_i,
  output logic [SliceSize-1:0]                rd_data_o,
  output logic [NumSlices*SliceSize-1:0]      ctr_o
);

  logic [NumSlices-1:0][SliceSize-1:0] ctr_q;

  for (genvar k = 0; k < NumSlices; k++) begin : g_slice
    // Hardware writes win; the controller never enables both on one slice.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)         ctr_q[k] <= '0;
      else if (hw_we_i[k]) ctr_q[k] <= hw_data_i;
      else if (sw_we_i[k]) ctr_q[k] <= sw_data_i[k];
    end
  end

  assign rd_data_o = ctr_q[rd_idx_i];
  assign ctr_o     = ctr_q;

endmodule

// File: rtl/prim_sparse_fsm_flop.sv
// State register for sparsely encoded FSMs; async active-low reset to ResetValue.
module prim_sparse_fsm_flop #(
  parameter int               Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] state_i,
  output logic [Width-1:0] state_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_o <= ResetValue;
    else         state_o <= state_i;
  end

endmodule

// File: rtl/aes_ctr_datapath.sv
// AES CTR counter datapath and increment controller in front of the slice FSM.
// Optional feature: AES_CTR_WRAP_FLAG_EN adds the full-counter wrap pulse.
module aes_ctr_datapath #(
  parameter  int NumSlices     = aes_pkg::NumSlicesCtr,
  parameter  int SliceSize     = aes_pkg::SliceSizeCtr,
  localparam int CtrWidth      = NumSlices * SliceSize,
  localparam int SliceIdxWidth = $clog2(NumSlices)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [CtrWidth-1:0]      iv_i,
  input  logic [NumSlices-1:0]     iv_we_i,
  input  logic                     incr_req_i,
  output logic                     incr_ack_o,
  output logic [CtrWidth-1:0]      ctr_o,
  output logic                     fsm_incr_o,
  input  logic                     fsm_ready_i,
  input  logic [SliceIdxWidth-1:0] fsm_slice_idx_i,
  output logic [SliceSize-1:0]     fsm_slice_o,
  input  logic [SliceSize-1:0]     fsm_slice_i,
  input  logic                     fsm_we_i,
  output logic                     incr_err_o,
  output logic                     ctr_wrap_o
);

  import aes_pkg::*;

  localparam int WdogWidth = $clog2(NumSlices + 3);

  logic [CtrStateWidth-1:0] state_d, state_q;
  logic [SliceIdxWidth-1:0] exp_idx_d, exp_idx_q;
  logic [WdogWidth-1:0]     wdog_d, wdog_q;
  logic [NumSlices-1:0]     sw_we, hw_we;

  always_comb begin
    state_d    = state_q;
    exp_idx_d  = exp_idx_q;
    wdog_d     = wdog_q;
    sw_we      = '0;
    hw_we      = '0;
    fsm_incr_o = 1'b0;
    incr_ack_o = 1'b0;
    case (state_q)
      CTR_IDLE: begin
        fsm_incr_o = incr_req_i & fsm_ready_i;
        if (fsm_we_i) begin
          state_d = CTR_ERROR;
        end else begin
          sw_we = iv_we_i;
          if (fsm_incr_o) begin
            exp_idx_d = '0;
            wdog_d    = '0;
            state_d   = CTR_BUSY;
          end
        end
      end
      CTR_BUSY: begin
        wdog_d = wdog_q + 1'b1;
        // IV writes and a stalled FSM abort the increment before any slice lands.
        if (|iv_we_i || wdog_q == WdogWidth'(NumSlices + 1)) begin
          state_d = CTR_ERROR;
        end else if (fsm_we_i) begin
          if (fsm_slice_idx_i == exp_idx_q) begin
            hw_we[fsm_slice_idx_i] = 1'b1;
            exp_idx_d = exp_idx_q + 1'b1;
            if (exp_idx_q == SliceIdxWidth'(NumSlices - 1)) state_d = CTR_DONE;
          end else begin
            state_d = CTR_ERROR;
          end
        end
      end
      CTR_DONE: begin
        incr_ack_o = 1'b1;
        if (fsm_we_i) begin
          state_d = CTR_ERROR;
        end else begin
          sw_we   = iv_we_i;
          state_d = CTR_IDLE;
        end
      end
      CTR_ERROR: state_d = CTR_ERROR;
      default:   state_d = CTR_ERROR;
    endcase
  end

  prim_sparse_fsm_flop #(
    .Width      (CtrStateWidth),
    .ResetValue (CTR_IDLE)
  ) u_state_regs (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .state_i (state_d),
    .state_o (state_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_idx_q <= '0;
      wdog_q    <= '0;
    end else begin
      exp_idx_q <= exp_idx_d;
      wdog_q    <= wdog_d;
    end
  end

  assign incr_err_o = (state_q == CTR_ERROR);

  aes_ctr_slice_regs #(
    .NumSlices (NumSlices),
    .SliceSize (SliceSize),
    .IdxWidth  (SliceIdxWidth)
  ) u_slice_regs (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .sw_we_i   (sw_we),
    .sw_data_i (iv_i),
    .hw_we_i   (hw_we),
    .hw_data_i (fsm_slice_i),
    .rd_idx_i  (fsm_slice_idx_i),
    .rd_data_o (fsm_slice_o),
    .ctr_o     (ctr_o)
  );

`ifdef AES_CTR_WRAP_FLAG_EN
  logic [CtrWidth-1:0] ctr_next;
  logic                zero_q;

  always_comb begin
    ctr_next = ctr_o;
    for (int k = 0; k < NumSlices; k++) begin
      if (hw_we[k])      ctr_next[k*SliceSize +: SliceSize] = fsm_slice_i;
      else if (sw_we[k]) ctr_next[k*SliceSize +: SliceSize] = iv_i[k*SliceSize +: SliceSize];
    end
  end

  // Zero flag tracks the post-write counter so DONE can report a wrap directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                zero_q <= 1'b1;
    else if (|hw_we || |sw_we)  zero_q <= (ctr_next == '0);
  end

  assign ctr_wrap_o = (state_q == CTR_DONE) & zero_q;
`else
  assign ctr_wrap_o = 1'b0;
`endif

endmodule
